// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
// Shared types and constants for the config packet loader and control_plane.
//   - cfg_state_e : loader FSM states
//   - cfg_err_e   : error codes reported on err_code
//   - header field offsets and default geometry (phit, columns, address width)
// -----------------------------------------------------------------------------
package config_loader_pkg;

    localparam int CFG_PHIT_SIZE    = 512;
    localparam int CFG_NUM_COL      = 5;
    localparam int CFG_DWIDTH_RFADD = 5;
    localparam int CFG_CNT_W        = 16;

    localparam logic [7:0] CFG_OP_WRITE = 8'hC1;

    // Header phit layout (LSB of each field)
    localparam int HDR_OP_LSB   = 0;
    localparam int HDR_COL_LSB  = 8;
    localparam int HDR_ADDR_LSB = 16;
    localparam int HDR_CNT_LSB  = 24;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2
    } cfg_state_e;

    typedef enum logic [1:0] {
        ERR_OPCODE = 2'd0,
        ERR_COLUMN = 2'd1,
        ERR_SHORT  = 2'd2,
        ERR_LONG   = 2'd3
    } cfg_err_e;

endpackage

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
// Parses config packets arriving on a phit-wide stream and turns them into
// row writes on the state_table / config_table write port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   s_tdata/s_tvalid/   input stream; s_tready depends only on hold
//   s_tready/s_tlast
//   hold                sequencer is reading tables: stop accepting beats
//   wr_add/wr_en/       registered table write port, wr_en one-hot per column
//   wr_data
//   busy                packet in progress (FSM not waiting for a header)
//   load_done           1-cycle pulse, packet written completely
//   err_valid/err_code  1-cycle error pulse; code holds between pulses
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int phit_size    = CFG_PHIT_SIZE,
    parameter int num_col      = CFG_NUM_COL,
    parameter int dwidth_RFadd = CFG_DWIDTH_RFADD,
    parameter int CNT_W        = CFG_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [phit_size-1:0]    s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic                    hold,
    output logic [dwidth_RFadd-1:0] wr_add,
    output logic [num_col-1:0]      wr_en,
    output logic [phit_size-1:0]    wr_data,
    output logic                    busy,
    output logic                    load_done,
    output logic                    err_valid,
    output logic [1:0]              err_code
);

    localparam logic [7:0]         COL_LIMIT = 8'(num_col);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [num_col-1:0] EN_ONE    = {{(num_col-1){1'b0}}, 1'b1};

    cfg_state_e              r_state,   w_state_nxt;
    logic [7:0]              r_col,     w_col_nxt;
    logic [dwidth_RFadd-1:0] r_addr,    w_addr_nxt;
    logic [CNT_W-1:0]        r_rem,     w_rem_nxt;

    logic [dwidth_RFadd-1:0] r_wr_add,  w_wr_add_nxt;
    logic [num_col-1:0]      r_wr_en,   w_wr_en_nxt;
    logic [phit_size-1:0]    r_wr_data, w_wr_data_nxt;
    logic                    r_done,    w_done_nxt;
    logic                    r_err,     w_err_nxt;
    cfg_err_e                r_code,    w_code_nxt;

    logic                    w_accept;
    logic [7:0]              w_hdr_op;
    logic [7:0]              w_hdr_col;
    logic [dwidth_RFadd-1:0] w_hdr_addr;
    logic [CNT_W-1:0]        w_hdr_cnt;

    // Ready never looks at valid, so upstream can rely on it combinationally.
    assign s_tready = !hold;
    assign w_accept = s_tvalid && !hold;

    // Header decode; only meaningful while in S_HDR.
    assign w_hdr_op   = s_tdata[HDR_OP_LSB   +: 8];
    assign w_hdr_col  = s_tdata[HDR_COL_LSB  +: 8];
    assign w_hdr_addr = s_tdata[HDR_ADDR_LSB +: dwidth_RFadd];
    assign w_hdr_cnt  = s_tdata[HDR_CNT_LSB  +: CNT_W];

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_addr_nxt    = r_addr;
        w_rem_nxt     = r_rem;
        w_wr_add_nxt  = r_wr_add;
        w_wr_en_nxt   = '0;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_code_nxt    = r_code;

        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    if (w_hdr_op != CFG_OP_WRITE) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_OPCODE;
                        if (!s_tlast) w_state_nxt = S_DRAIN;
                    end else if (w_hdr_col >= COL_LIMIT) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_COLUMN;
                        if (!s_tlast) w_state_nxt = S_DRAIN;
                    end else if (w_hdr_cnt == '0) begin
                        // Empty packet: legal only if the header is also the last phit.
                        if (s_tlast) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_LONG;
                            w_state_nxt = S_DRAIN;
                        end
                    end else if (s_tlast) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_SHORT;
                    end else begin
                        w_col_nxt   = w_hdr_col;
                        w_addr_nxt  = w_hdr_addr;
                        w_rem_nxt   = w_hdr_cnt;
                        w_state_nxt = S_DATA;
                    end
                end

                S_DATA: begin
                    // Every data beat is written, even the one that reveals an error.
                    w_wr_en_nxt   = EN_ONE << r_col;
                    w_wr_add_nxt  = r_addr;
                    w_wr_data_nxt = s_tdata;
                    w_addr_nxt    = r_addr + 1'b1;   // wraps at table depth
                    w_rem_nxt     = r_rem - 1'b1;
                    if (r_rem == CNT_ONE) begin
                        if (s_tlast) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_HDR;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_LONG;
                            w_state_nxt = S_DRAIN;
                        end
                    end else if (s_tlast) begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_SHORT;
                        w_state_nxt = S_HDR;
                    end
                end

                S_DRAIN: begin
                    if (s_tlast) w_state_nxt = S_HDR;
                end

                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HDR;
            r_col     <= '0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_wr_add  <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= ERR_OPCODE;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_addr    <= w_addr_nxt;
            r_rem     <= w_rem_nxt;
            r_wr_add  <= w_wr_add_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_code    <= w_code_nxt;
        end
    end

    assign wr_add    = r_wr_add;
    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign load_done = r_done;
    assign err_valid = r_err;
    assign err_code  = r_code;
    assign busy      = (r_state != S_HDR);

endmodule
